// File: rtl/memory_responder.sv
// memory_responder: wait-state word memory answering MAR/MDR requests.
// Ports: clk, clr (async low), MAR_out/MDR_out/read/write in; Mdatain/mem_ready/busy/error out.
module memory_responder #(
  parameter int ADDR_BITS   = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] MAR_out,
  input  logic [31:0] MDR_out,
  input  logic        read,
  input  logic        write,
  output logic [31:0] Mdatain,
  output logic        mem_ready,
  output logic        busy,
  output logic        error
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam int         DEPTH     = 1 << ADDR_BITS;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        op_wr;
  logic        op_bad;

  logic [31:0] mem [DEPTH];

  logic [ADDR_BITS-1:0] idx;
  logic                 oob;
  logic                 reject;
  logic                 fire;

  assign idx    = addr_q[ADDR_BITS-1:0];
  // any set bit above the implemented range
  assign oob    = (addr_q >> ADDR_BITS) != '0;
  assign reject = op_bad | oob;
  assign fire   = (state == ACCESS) && (cnt == 4'd0);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      addr_q    <= '0;
      data_q    <= '0;
      op_wr     <= 1'b0;
      op_bad    <= 1'b0;
      Mdatain   <= '0;
      mem_ready <= 1'b0;
      error     <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      error     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (read | write) begin
            addr_q <= MAR_out;
            data_q <= MDR_out;
            op_wr  <= write & ~read;
            op_bad <= read & write;
            cnt    <= WAIT_INIT;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state     <= DONE;
            mem_ready <= 1'b1;
            error     <= reject;
            if (!reject && !op_wr)
              Mdatain <= mem[idx];
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // array has no reset; an aborted access never reaches fire
  // because clr holds state in IDLE
  always_ff @(posedge clk) begin
    if (fire && op_wr && !reject)
      mem[idx] <= data_q;
  end

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: scoreboard bench for memory_responder.
// Directed vectors; monitor pops expectations on mem_ready.
module tb_memory_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] mar;
  logic [31:0] mdr;
  logic        rd;
  logic        wr;
  logic [31:0] mdata;
  logic        rdy;
  logic        bsy;
  logic        err;

  logic        rd0;
  logic [31:0] mar0;
  logic [31:0] mdr0;
  logic        wr0;
  logic [31:0] mdata0;
  logic        rdy0;
  logic        bsy0;
  logic        err0;

  always #5 clk = ~clk;

  memory_responder #(.ADDR_BITS(9), .WAIT_STATES(W)) dut (
    .clk(clk), .clr(clr),
    .MAR_out(mar), .MDR_out(mdr),
    .read(rd), .write(wr),
    .Mdatain(mdata), .mem_ready(rdy),
    .busy(bsy), .error(err)
  );

  memory_responder #(.ADDR_BITS(9), .WAIT_STATES(0)) dut0 (
    .clk(clk), .clr(clr),
    .MAR_out(mar0), .MDR_out(mdr0),
    .read(rd0), .write(wr0),
    .Mdatain(mdata0), .mem_ready(rdy0),
    .busy(bsy0), .error(err0)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  int          checks = 0;
  int          passed = 0;
  int          edges  = 0;
  logic [31:0] model [int];
  logic [31:0] exp_rd = '0;

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h want %h", name, act, req);
  endtask

  always @(negedge clk) begin
    if (clr && rdy) begin
      if (sbq.size() == 0) begin
        chk("spurious_ready", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("rdata", mdata, e.data);
        chk("error", {31'd0, err}, {31'd0, e.err});
        chk("latency", edges, e.due);
      end
    end
  end

  task automatic issue(input logic r, input logic w,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input bit track);
    int   n;
    bit   bad;
    exp_t x;
    n = 0;
    @(negedge clk);
    while (bsy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bsy) chk("idle_timeout", 32'd1, 32'd0);
    rd = r; wr = w; mar = a; mdr = d;
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0;
    chk("busy_accept", {31'd0, bsy}, 32'd1);
    if (track) begin
      bad = (r && w) || ((a >> 9) != 0);
      x.err = bad;
      if (!bad && w) begin
        model[int'(a)] = d;
      end else if (!bad) begin
        exp_rd = model.exists(int'(a)) ? model[int'(a)] : 32'hx;
      end
      x.data = exp_rd;
      x.due  = edges + W + 1;
      sbq.push_back(x);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || bsy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    clr = 1'b1;
    rd = 1'b0; wr = 1'b0; mar = '0; mdr = '0;
    rd0 = 1'b0; wr0 = 1'b0; mar0 = '0; mdr0 = '0;
    #1 clr = 1'b0;
    rd = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mdata", mdata, 32'h0);
    chk("rst_ready", {31'd0, rdy}, 32'd0);
    chk("rst_busy", {31'd0, bsy}, 32'd0);
    chk("rst_error", {31'd0, err}, 32'd0);
    rd = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {31'd0, bsy}, 32'd0);

    issue(1'b0, 1'b1, 32'h0, 32'hA5A50000, 1'b1);
    issue(1'b0, 1'b1, 32'h5, 32'hDEADBEEF, 1'b1);
    issue(1'b1, 1'b0, 32'h5, 32'h0, 1'b1);
    drain();
    chk("raw_5", mdata, 32'hDEADBEEF);

    issue(1'b1, 1'b0, 32'h200, 32'h0, 1'b1);
    drain();
    chk("oob_hold", mdata, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
    drain();
    chk("addr0", mdata, 32'hA5A50000);

    issue(1'b0, 1'b1, 32'h7, 32'h11111111, 1'b1);
    issue(1'b1, 1'b1, 32'h7, 32'h22222222, 1'b1);
    issue(1'b1, 1'b0, 32'h7, 32'h0, 1'b1);
    drain();
    chk("both_rej", mdata, 32'h11111111);

    issue(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 1'b1);
    mdr = 32'h0;
    mar = 32'h5;
    @(posedge clk);
    #1 rd = 1'b1;
    @(posedge clk);
    #1 rd = 1'b0;
    drain();
    issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
    drain();
    chk("latched_wr", mdata, 32'hCAFEF00D);

    issue(1'b0, 1'b1, 32'h20, 32'h0BADF00D, 1'b1);
    issue(1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
    drain();
    issue(1'b0, 1'b1, 32'h20, 32'h12345678, 1'b0);
    @(posedge clk);
    #2 clr = 1'b0;
    #1;
    chk("abort_mdata", mdata, 32'h0);
    chk("abort_busy", {31'd0, bsy}, 32'd0);
    chk("abort_ready", {31'd0, rdy}, 32'd0);
    chk("abort_error", {31'd0, err}, 32'd0);
    exp_rd = '0;
    @(negedge clk);
    clr = 1'b1;
    issue(1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
    drain();
    chk("abort_mem", mdata, 32'h0BADF00D);

    @(negedge clk);
    rd0 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("w0_ready", {31'd0, rdy0}, {31'd0, (i % 3) == 1});
      chk("w0_busy", {31'd0, bsy0}, {31'd0, (i % 3) != 2});
      chk("w0_error", {31'd0, err0}, 32'd0);
    end
    rd0 = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter: ADDR_BITS, default 9, number of implemented word-address bits (512 x 32-bit words).
REQ-002 Parameter: WAIT_STATES, default 2, extra cycles inserted before each access; legal range 0-15.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: clr  input  1  reset, asynchronous, active-low.
REQ-005 Port: MAR_out  input  32  word address from the datapath MAR.
REQ-006 Port: MDR_out  input  32  write data from the datapath MDR.
REQ-007 Port: read  input  1  read request strobe.
REQ-008 Port: write  input  1  write request strobe.
REQ-009 Port: Mdatain  output  32  read data returned toward the MDR input mux.
REQ-010 Port: mem_ready  output  1  one-cycle completion pulse.
REQ-011 Port: busy  output  1  high while a request is in progress (ACCESS or DONE).
REQ-012 Port: error  output  1  one-cycle pulse, coincident with mem_ready, flagging a rejected request.

Function
REQ-013 The FSM SHALL have three states: IDLE, ACCESS, DONE.
REQ-014 Strobes SHALL be sampled only in IDLE; in ACCESS and DONE they SHALL be ignored, with no queuing.
REQ-015 IDLE with exactly one of read/write high at an edge: latch MAR_out, MDR_out and the operation; load wait counter = WAIT_STATES; go to ACCESS.
REQ-016 ACCESS at each edge: counter != 0 -> decrement; counter == 0 -> perform the access and go to DONE.
REQ-017 The access SHALL be write: mem[addr] <= latched data; read: Mdatain <= mem[addr].
REQ-018 Latency: mem_ready SHALL be high during the cycle following edge E0+WAIT_STATES+1, where E0 is the accepting edge (WAIT_STATES=2: ready after the 3rd edge past accept).
REQ-019 DONE SHALL last exactly one cycle, drive mem_ready=1, and return to IDLE at the next edge.
REQ-020 A new request SHALL be acceptable at the edge that leaves DONE only if sampled in IDLE, so the minimum request spacing is WAIT_STATES+3 cycles.
REQ-021 read and write both high in IDLE: the request SHALL be accepted as a rejected op that follows the normal timing, skips the memory access, and pulses error with mem_ready.
REQ-022 Latched address bits [31:ADDR_BITS] nonzero: the request SHALL be rejected; no write; Mdatain unchanged; error pulses with mem_ready.
REQ-023 Mdatain SHALL hold its last read value; writes and rejected requests SHALL leave it unchanged.
REQ-024 busy SHALL be 1 in ACCESS and DONE and 0 in IDLE.
REQ-025 Only the latched address/data SHALL be used; changes on MAR_out/MDR_out after acceptance SHALL have no effect.
REQ-026 A read-after-write to the same address SHALL return the written data.

Reset
REQ-027 clr low SHALL immediately force state=IDLE, counter=0, Mdatain=0, mem_ready=0, busy=0, error=0, independent of clk.
REQ-028 Reset during ACCESS SHALL abort the request; a pending write SHALL NOT modify memory.
REQ-029 Memory array contents SHALL NOT be cleared by reset.
REQ-030 Strobes high while clr is low SHALL be ignored; the first sample SHALL be the first rising edge after clr deasserts.

Verification
REQ-031 Write 0xDEADBEEF to addr 0x05, then read addr 0x05 -> Mdatain=0xDEADBEEF; mem_ready pulses 3 edges after each accept (WAIT_STATES=2); error=0.
REQ-032 Read request with MAR_out=0x00000200 -> error=1 and mem_ready=1 in the same cycle; Mdatain keeps its prior value; a later read of addr 0x000 is unaffected.
REQ-033 read=write=1 with addr 0x07 (holding 0x11111111), MDR=0x22222222 -> error pulse; readback of 0x07 = 0x11111111.
REQ-034 Accept write 0xCAFEF00D to addr 0x10; change MDR to 0x0 and pulse read during ACCESS -> memory gets 0xCAFEF00D; second request ignored; one mem_ready only.
REQ-035 Accept write 0x12345678 to addr 0x20; assert clr in ACCESS -> outputs 0 immediately; after release, addr 0x20 reads its pre-write value.
REQ-036 WAIT_STATES=0: back-to-back reads with strobes held high -> mem_ready every 3rd cycle; busy low exactly one cycle between requests.
